// File: rtl/filter_xfade_mux.sv
// Click-free stereo source selector: linear crossfade over 2^RAMP_LOG2 sample ticks on a source change.
// Latency: outputs register on the sample_tick edge; a source switch takes 1 + 2^RAMP_LOG2 ticks to settle.
// Backpressure: none; the block advances only on sample_tick and holds its outputs between ticks.
module filter_xfade_mux #(
    parameter int WIDTH     = 32,
    parameter int NUM_SRC   = 4,
    parameter int SEL_W     = 2,
    parameter int RAMP_LOG2 = 6
) (
    input  logic                     AUD_BCLK,
    input  logic                     reset,
    input  logic                     sample_tick,
    input  logic [NUM_SRC*WIDTH-1:0] src_left_in,
    input  logic [NUM_SRC*WIDTH-1:0] src_right_in,
    input  logic [SEL_W-1:0]         filter_choice,
    output logic [WIDTH-1:0]         left_channel_audio_out,
    output logic [WIDTH-1:0]         right_channel_audio_out,
    output logic                     fade_active,
    output logic [SEL_W-1:0]         active_choice
);

    // Blend arithmetic width: holds a full-scale sample times 2^R plus sign, with no overflow.
    localparam int EW    = WIDTH + RAMP_LOG2 + 2;
    localparam int NSLOT = 1 << SEL_W;
    localparam logic [RAMP_LOG2:0] K_ONE     = {{RAMP_LOG2{1'b0}}, 1'b1};
    localparam logic [RAMP_LOG2:0] K_FULL    = {1'b1, {RAMP_LOG2{1'b0}}};
    localparam logic [SEL_W:0]     NUM_SRC_W = (SEL_W + 1)'(NUM_SRC);

    typedef enum logic {IDLE, FADE} state_t;

    state_t             state_q, state_d;
    logic [SEL_W-1:0]   active_q, active_d;
    logic [SEL_W-1:0]   target_q, target_d;
    logic [RAMP_LOG2:0] k_q, k_d;
    logic [WIDTH-1:0]   left_q, left_d;
    logic [WIDTH-1:0]   right_q, right_d;

    logic [RAMP_LOG2:0] kn;
    logic [SEL_W-1:0]   eff_choice;

    // Unpacked view of the sources; unused select codes read as silence.
    logic [WIDTH-1:0] src_l [NSLOT];
    logic [WIDTH-1:0] src_r [NSLOT];

    for (genvar i = 0; i < NSLOT; i++) begin : g_src
        if (i < NUM_SRC) begin : g_used
            assign src_l[i] = src_left_in[i*WIDTH +: WIDTH];
            assign src_r[i] = src_right_in[i*WIDTH +: WIDTH];
        end else begin : g_unused
            assign src_l[i] = '0;
            assign src_r[i] = '0;
        end
    end

    // (a*(2^R - kn) + b*kn) >>> R, signed, floor rounding; equal inputs pass through exactly.
    function automatic logic [WIDTH-1:0] blend(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b,
                                               input logic [RAMP_LOG2:0] kw);
        logic signed [EW-1:0] a_x, b_x, wa, wb, sum;
        a_x = EW'($signed(a));
        b_x = EW'($signed(b));
        wa  = EW'(K_FULL - kw);
        wb  = EW'(kw);
        sum = a_x * wa + b_x * wb;
        return WIDTH'(sum >>> RAMP_LOG2);
    endfunction

    // Next-state and output datapath; everything moves only on sample_tick.
    always_comb begin
        state_d  = state_q;
        active_d = active_q;
        target_d = target_q;
        k_d      = k_q;
        left_d   = left_q;
        right_d  = right_q;
        kn       = k_q + K_ONE;
        eff_choice = ({1'b0, filter_choice} >= NUM_SRC_W) ? '0 : filter_choice;
        if (sample_tick) begin
            case (state_q)
                IDLE: begin
                    // The tick that detects a change still plays the pure old source.
                    left_d  = src_l[active_q];
                    right_d = src_r[active_q];
                    if (eff_choice != active_q) begin
                        target_d = eff_choice;
                        k_d      = '0;
                        state_d  = FADE;
                    end
                end
                FADE: begin
                    // Choice changes are ignored here; IDLE re-evaluates the latest value.
                    if (kn == K_FULL) begin
                        left_d   = src_l[target_q];
                        right_d  = src_r[target_q];
                        active_d = target_q;
                        k_d      = '0;
                        state_d  = IDLE;
                    end else begin
                        left_d  = blend(src_l[active_q], src_l[target_q], kn);
                        right_d = blend(src_r[active_q], src_r[target_q], kn);
                        k_d     = kn;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State and output registers; reset clears everything immediately.
    always_ff @(posedge AUD_BCLK or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            active_q <= '0;
            target_q <= '0;
            k_q      <= '0;
            left_q   <= '0;
            right_q  <= '0;
        end else begin
            state_q  <= state_d;
            active_q <= active_d;
            target_q <= target_d;
            k_q      <= k_d;
            left_q   <= left_d;
            right_q  <= right_d;
        end
    end

    assign left_channel_audio_out  = left_q;
    assign right_channel_audio_out = right_q;
    assign fade_active             = (state_q == FADE);
    assign active_choice           = active_q;

endmodule

// File: tb/tb_filter_xfade_mux.sv
// Bench for filter_xfade_mux: three instances (R=2/4 sources, R=2/3 sources, R=6 extremes).
// Rows are queued as expectations when driven and popped after the tick edge.
// Right-channel sources are left+4, so right expectations are left+4 as well.
module tb_filter_xfade_mux;

    typedef struct {
        logic [1:0] ch;
        int         s0, s1, s2, s3;
        int         el;
        logic       ef;
        logic [1:0] ea;
    } vec_t;

    logic clk = 1'b0;
    logic rst, tick;
    logic [1:0] ch_a, ch_b, ch_c;
    int s [4];
    int cs0, cs1, cs2, cs3;
    logic [127:0] src_l_a, src_r_a, src_c;
    logic [31:0] la, ra, lb, rb, lc, rc;
    logic fa, fb, fc;
    logic [1:0] aa, ab, ac;

    int n_tests = 0;
    int n_fail  = 0;
    vec_t tbl [$];
    vec_t sb  [$];

    always #5 clk = ~clk;

    assign src_l_a = {s[3], s[2], s[1], s[0]};
    assign src_r_a = {s[3] + 4, s[2] + 4, s[1] + 4, s[0] + 4};

    filter_xfade_mux #(.WIDTH(32), .NUM_SRC(4), .SEL_W(2), .RAMP_LOG2(2)) dut_a (
        .AUD_BCLK(clk), .reset(rst), .sample_tick(tick),
        .src_left_in(src_l_a), .src_right_in(src_r_a), .filter_choice(ch_a),
        .left_channel_audio_out(la), .right_channel_audio_out(ra),
        .fade_active(fa), .active_choice(aa));

    filter_xfade_mux #(.WIDTH(32), .NUM_SRC(3), .SEL_W(2), .RAMP_LOG2(2)) dut_b (
        .AUD_BCLK(clk), .reset(rst), .sample_tick(tick),
        .src_left_in(src_l_a[95:0]), .src_right_in(src_r_a[95:0]), .filter_choice(ch_b),
        .left_channel_audio_out(lb), .right_channel_audio_out(rb),
        .fade_active(fb), .active_choice(ab));

    filter_xfade_mux #(.WIDTH(32), .NUM_SRC(4), .SEL_W(2), .RAMP_LOG2(6)) dut_c (
        .AUD_BCLK(clk), .reset(rst), .sample_tick(tick),
        .src_left_in(src_c), .src_right_in(src_c), .filter_choice(ch_c),
        .left_channel_audio_out(lc), .right_channel_audio_out(rc),
        .fade_active(fc), .active_choice(ac));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%h), expected %0d (0x%h)",
                     name, $signed(act), act, $signed(exp), exp);
        end
    endtask

    task automatic set_src(input int a, input int b, input int c, input int d);
        cs0 = a; cs1 = b; cs2 = c; cs3 = d;
    endtask

    task automatic row(input logic [1:0] ch, input int el, input logic ef, input logic [1:0] ea);
        vec_t v;
        v.ch = ch; v.s0 = cs0; v.s1 = cs1; v.s2 = cs2; v.s3 = cs3;
        v.el = el; v.ef = ef; v.ea = ea;
        tbl.push_back(v);
    endtask

    task automatic apply(input vec_t v, input string tag);
        vec_t e;
        @(negedge clk);
        ch_a = v.ch;
        s[0] = v.s0; s[1] = v.s1; s[2] = v.s2; s[3] = v.s3;
        tick = 1'b1;
        sb.push_back(v);
        @(posedge clk);
        #1;
        tick = 1'b0;
        if (sb.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL %s: scoreboard empty", tag);
        end else begin
            e = sb.pop_front();
            check({tag, " left"},   la, e.el);
            check({tag, " right"},  ra, e.el + 4);
            check({tag, " fade"},   32'(fa), 32'(e.ef));
            check({tag, " active"}, 32'(aa), 32'(e.ea));
            check({tag, " b_out3"}, lb, e.s0);
            check({tag, " b_fade"}, 32'(fb), 32'd0);
            @(negedge clk);
            @(negedge clk);
            check({tag, " hold"},   la, e.el);
        end
    endtask

    task automatic run_tbl(input string name);
        for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("%s[%0d]", name, i));
        tbl.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, " la"}, la, 32'd0);
        check({tag, " ra"}, ra, 32'd0);
        check({tag, " fa"}, 32'(fa), 32'd0);
        check({tag, " aa"}, 32'(aa), 32'd0);
        check({tag, " lb"}, lb, 32'd0);
        check({tag, " lc"}, lc, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        longint ex, prev;
        rst = 1'b1; tick = 1'b0;
        ch_a = 2'd0; ch_b = 2'd3; ch_c = 2'd0;
        s[0] = 0; s[1] = 0; s[2] = 0; s[3] = 0;
        src_c = '0;
        repeat (2) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;
        @(negedge clk);
        check_zero("post_reset");

        // Steady dry path, then a 0->1 fade.
        set_src(1000, -1000, 2222, 4000);
        row(0, 1000, 0, 0); row(0, 1000, 0, 0); row(0, 1000, 0, 0);
        row(1, 1000, 1, 0); row(1, 500, 1, 0); row(1, 0, 1, 0);
        row(1, -500, 1, 0); row(1, -1000, 0, 1); row(1, -1000, 0, 1);
        run_tbl("fade01");

        // Mid-fade requests 2 then 3: 2 is dropped, 3 follows; then return-to-origin.
        do_reset();
        row(1, 1000, 1, 0); row(2, 500, 1, 0); row(3, 0, 1, 0);
        row(3, -500, 1, 0); row(3, -1000, 0, 1);
        row(3, -1000, 1, 1); row(3, 250, 1, 1); row(3, 1500, 1, 1);
        row(3, 2750, 1, 1); row(3, 4000, 0, 3);
        row(0, 4000, 1, 3); row(0, 3250, 1, 3); row(3, 2500, 1, 3);
        row(3, 1750, 1, 3); row(3, 1000, 0, 0);
        row(3, 1000, 1, 0); row(3, 1750, 1, 0); row(3, 2500, 1, 0);
        row(3, 3250, 1, 0); row(3, 4000, 0, 3);
        run_tbl("midfade");

        // Async reset at k=2, then a fresh fade.
        do_reset();
        row(1, 1000, 1, 0); row(1, 500, 1, 0); row(1, 0, 1, 0);
        run_tbl("pre_arst");
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_zero("arst_mid");
        @(negedge clk);
        rst = 1'b0;
        row(1, 1000, 1, 0); row(1, 500, 1, 0); row(1, 0, 1, 0);
        row(1, -500, 1, 0); row(1, -1000, 0, 1);
        run_tbl("post_arst");

        // Floor rounding of negative blends.
        do_reset();
        set_src(-1, 0, 0, 0);
        row(1, -1, 1, 0); row(1, -1, 1, 0); row(1, -1, 1, 0);
        row(1, -1, 1, 0); row(1, 0, 0, 1);
        run_tbl("floor");

        // Equal sources: exact passthrough on every tick; then fresh sampling when idle.
        set_src(-7, -7, 0, 0);
        row(0, -7, 1, 1); row(0, -7, 1, 1); row(0, -7, 1, 1);
        row(0, -7, 1, 1); row(0, -7, 0, 0);
        set_src(5, -7, 0, 0);
        row(0, 5, 0, 0);
        run_tbl("equal");

        // Full-scale extremes over a 64-tick ramp.
        do_reset();
        src_c = {32'd0, 32'd0, 32'h8000_0000, 32'h7FFF_FFFF};
        ch_c = 2'd1;
        prev = 64'sd2147483647;
        for (int t = 0; t <= 64; t++) begin
            @(negedge clk);
            tick = 1'b1;
            @(posedge clk);
            #1;
            tick = 1'b0;
            if (t == 0) ex = 64'sd2147483647;
            else ex = (64'sd2147483647 * longint'(64 - t) + (-64'sd2147483648) * longint'(t)) >>> 6;
            check($sformatf("ext[%0d] left", t), lc, ex[31:0]);
            check($sformatf("ext[%0d] right", t), rc, ex[31:0]);
            n_tests++;
            if (longint'($signed(lc)) > prev) begin
                n_fail++;
                $display("FAIL ext[%0d] monotonic: got %0d after %0d", t, $signed(lc), prev);
            end
            prev = longint'($signed(lc));
            check($sformatf("ext[%0d] fade", t), 32'(fc), (t == 64) ? 32'd0 : 32'd1);
        end
        check("ext active", 32'(ac), 32'd1);
        check("ext final", lc, 32'h8000_0000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
